// File: rtl/lut_cfg_pkg.sv
// Shared definitions for the run-time LUT5 configuration writer.
package lut_cfg_pkg;

  localparam int LUT_ADDR_W = 5;
  localparam int LUT_DEPTH  = 32;
  localparam int CNT_W      = 6;

  // Count value on which the final shift of a word happens.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LUT_DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/lut5_cfg_table.sv
// Truth-table register with serial shift-in, combinational lookup and
// cascade output (the bit that leaves the table on the next shift).
module lut5_cfg_table
  import lut_cfg_pkg::*;
#(
  parameter logic [LUT_DEPTH-1:0] INIT = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  shift_en,
  input  logic                  shift_bit,
  input  logic [LUT_ADDR_W-1:0] adr,
  output logic                  o,
  output logic                  cdo
);

  logic [LUT_DEPTH-1:0] table_q;
  logic [LUT_DEPTH-1:0] table_d;

  // Next table: shift one bit in at the LSB when enabled, else hold.
  always_comb begin
    // NOTE: default-assign first so every path drives table_d; otherwise a latch is inferred.
    table_d = table_q;
    if (shift_en) begin
      table_d = {table_q[LUT_DEPTH-2:0], shift_bit};
    end
  end

  // Table register; synchronous reset reloads the static INIT contents.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      table_q <= INIT;
    end else begin
      table_q <= table_d;
    end
  end

  // Zero-latency lookup, valid mid-shift too (consumers qualify with BUSY).
  assign o   = table_q[adr];
  assign cdo = table_q[LUT_DEPTH-1];

endmodule

// File: rtl/lut5_cfg_writer.sv
// Run-time writer for a 5-input LUT: accepts a 32-bit truth-table word over
// valid/ready and shifts it MSB first into the table, one bit per CE cycle.
module lut5_cfg_writer
  import lut_cfg_pkg::*;
#(
  parameter logic [LUT_DEPTH-1:0] INIT = 32'h0000_0000,
  parameter                       LOC  = "UNPLACED"
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [LUT_DEPTH-1:0] CFG_DATA,
  input  logic                 CFG_VALID,
  output logic                 CFG_READY,
  input  logic                 CE,
  input  logic                 ADR0,
  input  logic                 ADR1,
  input  logic                 ADR2,
  input  logic                 ADR3,
  input  logic                 ADR4,
  output logic                 O,
  output logic                 CDO,
  output logic                 BUSY,
  output logic                 DONE
);

  // Placement attribute only; it never changes the function.
  if (LOC != "UNPLACED") begin : g_placed
  end

  state_e               state_q, state_d;
  logic [LUT_DEPTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 accept;
  logic                 shift_en;

  // Handshake, shift sequencing and next values of the registered outputs.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    shift_en = 1'b0;
    accept   = CFG_VALID && ready_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          shreg_d = CFG_DATA;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (CE) begin
          shift_en = 1'b1;
          shreg_d  = {shreg_q[LUT_DEPTH-2:0], 1'b0};
          // Count stops at 31 on the final shift; it restarts on acceptance.
          if (cnt_q == LAST_CNT) begin
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        // Accepting here removes the IDLE bubble for back-to-back words.
        if (accept) begin
          shreg_d = CFG_DATA;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    ready_d = (state_d != ST_SHIFT);
    busy_d  = (state_d == ST_SHIFT);
    done_d  = (state_d == ST_DONE);
  end

  // Controller state and registered outputs; reset overrides everything.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  lut5_cfg_table #(
    .INIT (INIT)
  ) u_table (
    .clk       (CLK),
    .rst       (RST),
    .shift_en  (shift_en),
    .shift_bit (shreg_q[LUT_DEPTH-1]),
    .adr       ({ADR4, ADR3, ADR2, ADR1, ADR0}),
    .o         (O),
    .cdo       (CDO)
  );

  assign CFG_READY = ready_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;

endmodule

// File: tb/tb_lut5_cfg_writer.sv
// Self-checking bench for lut5_cfg_writer: directed test-plan steps plus
// randomized loads against a word-level table model.
module tb_lut5_cfg_writer;

  localparam logic [31:0] INIT_VAL = 32'h8000_0001;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cfg_data;
  logic        cfg_valid;
  logic        cfg_ready;
  logic        ce;
  logic [4:0]  adr;
  logic        o;
  logic        cdo;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Model: the table as a whole word, replaced when a load completes.
  logic [31:0] model_tbl;

  lut5_cfg_writer #(
    .INIT (INIT_VAL),
    .LOC  ("UNPLACED")
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .CFG_DATA  (cfg_data),
    .CFG_VALID (cfg_valid),
    .CFG_READY (cfg_ready),
    .CE        (ce),
    .ADR0      (adr[0]),
    .ADR1      (adr[1]),
    .ADR2      (adr[2]),
    .ADR3      (adr[3]),
    .ADR4      (adr[4]),
    .O         (o),
    .CDO       (cdo),
    .BUSY      (busy),
    .DONE      (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; return 1 ns after the edge so outputs are settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input string tag, input int a, input logic exp);
    adr = 5'(a);
    #1;
    check(tag, {31'd0, o}, {31'd0, exp});
  endtask

  task automatic lookup_random(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      int a;
      a = int'($urandom_range(0, 31));
      lookup(tag, a, model_tbl[a]);
    end
  endtask

  task automatic check_idle_flags(input string tag);
    check({tag, "_ready"}, {31'd0, cfg_ready}, 32'd1);
    check({tag, "_busy"},  {31'd0, busy},      32'd0);
  endtask

  // Runs from just after the acceptance edge until DONE is seen (bounded).
  // Stalls exactly n_stalls CE cycles; optionally pulses a junk word on
  // CFG_VALID while busy. Checks CDO streams the previous table MSB first.
  task automatic shift_phase(input logic [31:0] prev, input logic [31:0] word,
                             input int n_stalls, input bit junk, output int done_cyc);
    int k;
    int lat;
    int stalls;
    k = 0;
    lat = 0;
    stalls = n_stalls;
    done_cyc = -1;
    while (done !== 1'b1 && lat < 100) begin
      check("busy_during_shift",  {31'd0, busy},      32'd1);
      check("ready_during_shift", {31'd0, cfg_ready}, 32'd0);
      if (k < 32) check("cdo_stream", {31'd0, cdo}, {31'd0, prev[31-k]});
      ce = 1'b1;
      if (stalls > 0 && ($urandom_range(0, 3) == 0 || stalls >= 32 - k)) begin
        ce = 1'b0;
        stalls--;
      end
      if (junk) begin
        cfg_valid = (lat == 3);
        cfg_data  = $urandom;
      end
      tick();
      lat++;
      if (ce) k++;
    end
    ce = 1'b1;
    if (junk) cfg_valid = 1'b0;
    check("done_seen", {31'd0, done}, 32'd1);
    check("load_latency", lat, 32 + n_stalls);
    check("busy_at_done",  {31'd0, busy},      32'd0);
    check("ready_at_done", {31'd0, cfg_ready}, 32'd1);
    done_cyc = cyc;
    model_tbl = word;
    lookup_random("lookup_after_load", 6);
  endtask

  // Presents a word while idle and completes the handshake on the next edge.
  task automatic offer(input logic [31:0] word);
    cfg_data  = word;
    cfg_valid = 1'b1;
    check("ready_before_accept", {31'd0, cfg_ready}, 32'd1);
    tick();
    cfg_valid = 1'b0;
  endtask

  initial begin
    int d1;
    int d2;
    bit seen;
    logic [31:0] prev;

    rst = 1'b1;
    cfg_data = '0;
    cfg_valid = 1'b0;
    ce = 1'b1;
    adr = '0;

    // Reset state.
    tick();
    tick();
    rst = 1'b0;
    model_tbl = INIT_VAL;
    check_idle_flags("reset");
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_cdo",  {31'd0, cdo},  32'd1);
    lookup("reset_o_adr0",  0,  1'b1);
    lookup("reset_o_adr31", 31, 1'b1);
    lookup("reset_o_adr5",  5,  1'b0);

    // Plain load with CE held high; CDO carries the INIT word out.
    tick();
    offer(32'hA5A5_0F0F);
    shift_phase(INIT_VAL, 32'hA5A5_0F0F, 0, 1'b0, d1);
    lookup("load_o_adr0",  0,  1'b1);
    lookup("load_o_adr4",  4,  1'b0);
    lookup("load_o_adr31", 31, 1'b1);
    tick();
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check_idle_flags("after_load");

    // Same word with 5 scattered CE stalls: latency 37.
    offer(32'hA5A5_0F0F);
    shift_phase(32'hA5A5_0F0F, 32'hA5A5_0F0F, 5, 1'b0, d1);
    tick();

    // Back-to-back: valid held, second word accepted in the DONE cycle.
    cfg_data  = 32'hFFFF_FFFF;
    cfg_valid = 1'b1;
    tick();
    cfg_data = 32'h0000_0000;
    shift_phase(32'hA5A5_0F0F, 32'hFFFF_FFFF, 0, 1'b0, d1);
    tick();
    cfg_valid = 1'b0;
    check("b2b_accept_in_done", {31'd0, busy}, 32'd1);
    check("b2b_done_dropped",   {31'd0, done}, 32'd0);
    shift_phase(32'hFFFF_FFFF, 32'h0000_0000, 0, 1'b0, d2);
    check("b2b_spacing", d2 - d1, 33);
    for (int a = 0; a < 32; a++) lookup("b2b_all_zero", a, 1'b0);
    tick();

    // Reset after 10 shifts of 32'h1234_5678: table back to INIT, no DONE.
    offer(32'h1234_5678);
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_tbl = INIT_VAL;
    check_idle_flags("midshift_reset");
    check("midshift_reset_done", {31'd0, done}, 32'd0);
    for (int a = 0; a < 32; a++) lookup("midshift_reset_table", a, model_tbl[a]);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    check("no_done_after_reset", {31'd0, seen}, 32'd0);

    // Randomized loads with stalls, idle gaps and junk valid pulses while busy.
    for (int n = 0; n < 5; n++) begin
      logic [31:0] word;
      int gap;
      word = $urandom;
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) tick();
      prev = model_tbl;
      offer(word);
      shift_phase(prev, word, int'($urandom_range(0, 6)), 1'b1, d1);
      tick();
      check("rand_done_pulse", {31'd0, done}, 32'd0);
      check_idle_flags("rand_idle");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
